// File: rtl/decode.sv
// AAP decode stage: takes 16-bit words from fetch, joins 32-bit instructions from
// two words, and registers the decoded fields for execute.
module decode #(
  parameter int PC_W = 20
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     fetchoutput,
  input  logic            word_valid,
  input  logic [PC_W-1:0] word_pc,
  input  logic            flush,
  input  logic            stall_in,
  output logic            stall_out,
  output logic            dec_valid,
  output logic [PC_W-1:0] dec_pc,
  output logic            dec_len,
  output logic [1:0]      dec_class,
  output logic [5:0]      dec_opcode,
  output logic [5:0]      dec_rd,
  output logic [5:0]      dec_ra,
  output logic [5:0]      dec_rb,
  output logic [15:0]     dec_imm,
  output logic            dec_illegal,
  output logic            dbg_state
);

  // Handshake: a word is taken when word_valid is high and stall_out is low;
  // stall_out rises only when execute refuses a valid decode output.

  typedef enum logic {
    ST_FIRST  = 1'b0,
    ST_SECOND = 1'b1
  } state_t;

  state_t          state, state_next;
  logic [15:0]     hold_word;
  logic [PC_W-1:0] hold_pc;

  logic [15:0] word;
  logic        accept;
  logic        emit;
  logic        load_hold;

  logic [PC_W-1:0] nxt_pc;
  logic            nxt_len;
  logic [1:0]      nxt_class;
  logic [5:0]      nxt_opcode;
  logic [5:0]      nxt_rd;
  logic [5:0]      nxt_ra;
  logic [5:0]      nxt_rb;
  logic [15:0]     nxt_imm;
  logic            nxt_illegal;

  assign word      = fetchoutput[15:0];
  assign stall_out = stall_in & dec_valid;
  assign accept    = word_valid & ~stall_out;
  assign dbg_state = state;

  always_comb begin
    state_next  = state;
    emit        = 1'b0;
    load_hold   = 1'b0;
    nxt_pc      = word_pc;
    nxt_len     = 1'b0;
    nxt_class   = word[14:13];
    nxt_opcode  = {2'b00, word[12:9]};
    nxt_rd      = {3'b000, word[8:6]};
    nxt_ra      = {3'b000, word[5:3]};
    nxt_rb      = {3'b000, word[2:0]};
    nxt_imm     = {{13{word[2]}}, word[2:0]};
    nxt_illegal = 1'b0;
    case (state)
      ST_FIRST: begin
        if (accept) begin
          if (word[15]) begin
            load_hold  = 1'b1;
            state_next = ST_SECOND;
          end else begin
            emit = 1'b1;
          end
        end
      end
      ST_SECOND: begin
        if (accept) begin
          // Low bits of every field come from the first word; l[12:9] is reserved.
          emit        = 1'b1;
          state_next  = ST_FIRST;
          nxt_pc      = hold_pc;
          nxt_len     = 1'b1;
          nxt_class   = hold_word[14:13];
          nxt_opcode  = {word[14:13], hold_word[12:9]};
          nxt_rd      = {word[8:6], hold_word[8:6]};
          nxt_ra      = {word[5:3], hold_word[5:3]};
          nxt_rb      = {word[2:0], hold_word[2:0]};
          nxt_imm     = {{10{word[2]}}, word[2:0], hold_word[2:0]};
          nxt_illegal = word[15];
        end
      end
      default: state_next = ST_FIRST;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_FIRST;
      hold_word   <= '0;
      hold_pc     <= '0;
      dec_valid   <= 1'b0;
      dec_pc      <= '0;
      dec_len     <= 1'b0;
      dec_class   <= '0;
      dec_opcode  <= '0;
      dec_rd      <= '0;
      dec_ra      <= '0;
      dec_rb      <= '0;
      dec_imm     <= '0;
      dec_illegal <= 1'b0;
    end else if (flush) begin
      state     <= ST_FIRST;
      hold_word <= '0;
      hold_pc   <= '0;
      dec_valid <= 1'b0;
    end else if (!(stall_in && dec_valid)) begin
      state     <= state_next;
      dec_valid <= emit;
      if (load_hold) begin
        hold_word <= word;
        hold_pc   <= word_pc;
      end
      // A bubble leaves the field outputs at their last values.
      if (emit) begin
        dec_pc      <= nxt_pc;
        dec_len     <= nxt_len;
        dec_class   <= nxt_class;
        dec_opcode  <= nxt_opcode;
        dec_rd      <= nxt_rd;
        dec_ra      <= nxt_ra;
        dec_rb      <= nxt_rb;
        dec_imm     <= nxt_imm;
        dec_illegal <= nxt_illegal;
      end
    end
  end

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: 16/32-bit decode, bubbles, stall, flush and reset.
module tb_decode;

  localparam int PC_W = 20;

  logic            clock;
  logic            reset;
  logic [31:0]     fetchoutput;
  logic            word_valid;
  logic [PC_W-1:0] word_pc;
  logic            flush;
  logic            stall_in;
  logic            stall_out;
  logic            dec_valid;
  logic [PC_W-1:0] dec_pc;
  logic            dec_len;
  logic [1:0]      dec_class;
  logic [5:0]      dec_opcode;
  logic [5:0]      dec_rd;
  logic [5:0]      dec_ra;
  logic [5:0]      dec_rb;
  logic [15:0]     dec_imm;
  logic            dec_illegal;
  logic            dbg_state;

  int checks = 0;
  int errors = 0;

  decode #(.PC_W(PC_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .fetchoutput (fetchoutput),
    .word_valid  (word_valid),
    .word_pc     (word_pc),
    .flush       (flush),
    .stall_in    (stall_in),
    .stall_out   (stall_out),
    .dec_valid   (dec_valid),
    .dec_pc      (dec_pc),
    .dec_len     (dec_len),
    .dec_class   (dec_class),
    .dec_opcode  (dec_opcode),
    .dec_rd      (dec_rd),
    .dec_ra      (dec_ra),
    .dec_rb      (dec_rb),
    .dec_imm     (dec_imm),
    .dec_illegal (dec_illegal),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] w, input logic [PC_W-1:0] pc);
    word_valid  = v;
    fetchoutput = {16'hDEAD, w};
    word_pc     = pc;
  endtask

  task automatic check_dec(input string tag, input logic v, input logic len,
                           input logic [1:0] cls, input logic [5:0] op,
                           input logic [5:0] rd, input logic [5:0] ra, input logic [5:0] rb,
                           input logic [15:0] imm, input logic [PC_W-1:0] pc, input logic ill);
    check({tag, ".valid"},   32'(dec_valid),   32'(v));
    check({tag, ".len"},     32'(dec_len),     32'(len));
    check({tag, ".class"},   32'(dec_class),   32'(cls));
    check({tag, ".opcode"},  32'(dec_opcode),  32'(op));
    check({tag, ".rd"},      32'(dec_rd),      32'(rd));
    check({tag, ".ra"},      32'(dec_ra),      32'(ra));
    check({tag, ".rb"},      32'(dec_rb),      32'(rb));
    check({tag, ".imm"},     32'(dec_imm),     32'(imm));
    check({tag, ".pc"},      32'(dec_pc),      32'(pc));
    check({tag, ".illegal"}, 32'(dec_illegal), 32'(ill));
  endtask

  task automatic pair32(input logic [15:0] h, input logic [15:0] l, input string tag);
    drive(1'b1, h, 20'h00020);
    tick();
    drive(1'b0, 16'h0000, 20'h00000);
    check({tag, ".hi_state"}, 32'(dbg_state), 32'd1);
    check({tag, ".hi_bubble"}, 32'(dec_valid), 32'd0);
    tick();
    check({tag, ".gap1"}, 32'(dec_valid), 32'd0);
    tick();
    check({tag, ".gap2"}, 32'(dec_valid), 32'd0);
    drive(1'b1, l, 20'h00021);
    tick();
    drive(1'b0, 16'h0000, 20'h00000);
    check_dec(tag, 1'b1, 1'b1, 2'd0, 6'h31, 6'h39, 6'h39, 6'h39, 16'hFFF9, 20'h00020, l[15]);
    check({tag, ".state"}, 32'(dbg_state), 32'd0);
    tick();
    check({tag, ".after"}, 32'(dec_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    stall_in = 1'b0;
    drive(1'b0, 16'h0000, 20'h00000);
    tick();
    tick();
    check_dec("rst", 1'b0, 1'b0, 2'd0, 6'h00, 6'h00, 6'h00, 6'h00, 16'h0000, 20'h00000, 1'b0);
    check("rst.stall_out", 32'(stall_out), 32'd0);
    reset = 1'b0;

    // 16-bit instruction, one-cycle latency
    drive(1'b1, 16'h0A5B, 20'h00010);
    tick();
    drive(1'b0, 16'h0000, 20'h00000);
    check_dec("i16", 1'b1, 1'b0, 2'd0, 6'h05, 6'h01, 6'h03, 6'h03, 16'h0003, 20'h00010, 1'b0);
    tick();
    check("i16.bubble", 32'(dec_valid), 32'd0);
    check("i16.bubble_pc", 32'(dec_pc), 32'h00010);

    pair32(16'h8249, 16'h71FF, "i32");
    pair32(16'h8249, 16'hF1FF, "i32ill");

    // stall holds outputs and does not lose or duplicate the presented word
    drive(1'b1, 16'h0A5B, 20'h00030);
    tick();
    stall_in = 1'b1;
    drive(1'b1, 16'h0001, 20'h00031);
    #1;
    check("stall.out", 32'(stall_out), 32'd1);
    tick();
    check_dec("stall1", 1'b1, 1'b0, 2'd0, 6'h05, 6'h01, 6'h03, 6'h03, 16'h0003, 20'h00030, 1'b0);
    tick();
    check_dec("stall2", 1'b1, 1'b0, 2'd0, 6'h05, 6'h01, 6'h03, 6'h03, 16'h0003, 20'h00030, 1'b0);
    check("stall2.out", 32'(stall_out), 32'd1);
    stall_in = 1'b0;
    #1;
    check("release.out", 32'(stall_out), 32'd0);
    tick();
    drive(1'b0, 16'h0000, 20'h00000);
    check_dec("release", 1'b1, 1'b0, 2'd0, 6'h00, 6'h00, 6'h00, 6'h01, 16'h0001, 20'h00031, 1'b0);
    tick();
    check("release.nodup", 32'(dec_valid), 32'd0);

    // flush drops the held half and the word presented with it
    drive(1'b1, 16'h8249, 20'h00040);
    tick();
    check("flush.pre_state", 32'(dbg_state), 32'd1);
    flush = 1'b1;
    drive(1'b1, 16'h71FF, 20'h00041);
    tick();
    flush = 1'b0;
    drive(1'b0, 16'h0000, 20'h00000);
    check("flush.valid", 32'(dec_valid), 32'd0);
    check("flush.state", 32'(dbg_state), 32'd0);
    drive(1'b1, 16'h0A5B, 20'h00050);
    tick();
    drive(1'b0, 16'h0000, 20'h00000);
    check_dec("postflush", 1'b1, 1'b0, 2'd0, 6'h05, 6'h01, 6'h03, 6'h03, 16'h0003, 20'h00050, 1'b0);

    // reset while holding a first half
    drive(1'b1, 16'h8249, 20'h00060);
    tick();
    drive(1'b0, 16'h0000, 20'h00000);
    check("rst2.pre_state", 32'(dbg_state), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_dec("rst2", 1'b0, 1'b0, 2'd0, 6'h00, 6'h00, 6'h00, 6'h00, 16'h0000, 20'h00000, 1'b0);
    check("rst2.state", 32'(dbg_state), 32'd0);

    // reset while stalled
    drive(1'b1, 16'h0A5B, 20'h00070);
    tick();
    drive(1'b0, 16'h0000, 20'h00000);
    stall_in = 1'b1;
    #1;
    check("rst3.pre_stall", 32'(stall_out), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_dec("rst3", 1'b0, 1'b0, 2'd0, 6'h00, 6'h00, 6'h00, 6'h00, 16'h0000, 20'h00000, 1'b0);
    check("rst3.stall_out", 32'(stall_out), 32'd0);
    stall_in = 1'b0;

    // held half really dropped: next word decodes as 16-bit
    drive(1'b1, 16'h0A5B, 20'h00080);
    tick();
    drive(1'b0, 16'h0000, 20'h00000);
    check_dec("postrst", 1'b1, 1'b0, 2'd0, 6'h05, 6'h01, 6'h03, 6'h03, 16'h0003, 20'h00080, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
